// File: rtl/tft_spi_pkg.sv
// Shared definitions for the TFT panel blocks: FSM encoding and divider defaults.
package tft_spi_pkg;

  // Serialiser FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } tft_state_t;

  // Default clk cycles per SCLK half-period
  localparam int unsigned TFT_CLK_DIV_DEF = 2;

  // Counter widths
  localparam int unsigned TFT_CNT_W = 8;
  localparam int unsigned TFT_BIT_W = 3;

endpackage

// File: rtl/tft_spi.sv
// Byte-wide SPI mode-0 transmitter for a TFT panel, with D/C line and chip select.
// Every output is a flop; one byte keeps tft_busy high for 17*CLK_DIV cycles.
module tft_spi
  import tft_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = TFT_CLK_DIV_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tft_transmit,
  input  logic       tft_dc,
  input  logic [7:0] tft_data,
  output logic       tft_busy,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs,
  output logic       spi_dc
);

  localparam logic [TFT_CNT_W-1:0] DIV_LAST = TFT_CNT_W'(CLK_DIV - 1);

  tft_state_t           state_q, state_d;
  logic [TFT_CNT_W-1:0] cnt_q, cnt_d;
  logic [TFT_BIT_W-1:0] bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 busy_q, busy_d;
  logic                 sclk_q, sclk_d;
  logic                 mosi_q, mosi_d;
  logic                 cs_q, cs_d;
  logic                 dc_q, dc_d;

  logic                 half_done;

  assign half_done = (cnt_q == DIV_LAST);

  // Next-state and next-output logic; every register holds unless a phase ends.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    busy_d  = busy_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    dc_d    = dc_q;
    case (state_q)
      IDLE: begin
        if (tft_transmit) begin
          shreg_d = tft_data;
          dc_d    = tft_dc;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          mosi_d  = tft_data[7];
          sclk_d  = 1'b0;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = LOW;
        end
      end
      LOW: begin
        if (half_done) begin
          cnt_d   = '0;
          sclk_d  = 1'b1;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HIGH: begin
        if (half_done) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == 3'd7) begin
            // Last bit clocked out: release the panel, then hold busy one more half-period
            cs_d    = 1'b1;
            state_d = DONE;
          end else begin
            shreg_d = {shreg_q[6:0], 1'b0};
            mosi_d  = shreg_q[6];
            bit_d   = bit_q + 1'b1;
            state_d = LOW;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (half_done) begin
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, shifter and output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      busy_q  <= 1'b0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      dc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      dc_q    <= dc_d;
    end
  end

  assign tft_busy = busy_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_cs   = cs_q;
  assign spi_dc   = dc_q;

endmodule

// File: tb/tb_tft_spi.sv
// Directed bench for tft_spi: one instance at the default divider, one at CLK_DIV=1.
module tb_tft_spi;

  logic       clk = 1'b0;
  logic       rst;

  logic       t2, dc2;
  logic [7:0] d2;
  logic       busy2, sclk2, mosi2, cs2, spidc2;

  logic       t1, dc1;
  logic [7:0] d1;
  logic       busy1, sclk1, mosi1, cs1, spidc1;

  int n_checks = 0;
  int n_errors = 0;
  int cs_run   = 0;
  int gap_last = 0;

  always #5 clk = ~clk;

  tft_spi u_div2 (
    .clk(clk), .rst(rst), .tft_transmit(t2), .tft_dc(dc2), .tft_data(d2),
    .tft_busy(busy2), .spi_sclk(sclk2), .spi_mosi(mosi2), .spi_cs(cs2), .spi_dc(spidc2)
  );

  tft_spi #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .tft_transmit(t1), .tft_dc(dc1), .tft_data(d1),
    .tft_busy(busy1), .spi_sclk(sclk1), .spi_mosi(mosi1), .spi_cs(cs1), .spi_dc(spidc1)
  );

  // Length of the most recent spi_cs high run of the default-divider instance
  always @(negedge clk) begin
    if (cs2 === 1'b1) begin
      cs_run = cs_run + 1;
    end else if (cs2 === 1'b0) begin
      if (cs_run > 0) gap_last = cs_run;
      cs_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Send one byte on the default instance and check its framing and bit stream.
  // An optional stray transmit pulse is driven at busy cycle inj_cycle.
  task automatic send_byte(input string tag, input logic dc, input logic [7:0] data,
                           input int inj_cycle, input logic [7:0] inj_data);
    int nb, ncs, nr, ndc_bad, guard;
    logic [7:0] bits;
    logic prev;
    nb = 0; ncs = 0; nr = 0; ndc_bad = 0; guard = 0; bits = 8'h00; prev = 1'b0;
    t2 = 1'b1; dc2 = dc; d2 = data;
    tick;
    t2 = 1'b0; dc2 = ~dc; d2 = ~data;
    while (busy2 === 1'b1 && guard < 200) begin
      nb++;
      if (cs2 === 1'b0) ncs++;
      if (spidc2 !== dc) ndc_bad++;
      if (sclk2 === 1'b1 && prev === 1'b0) begin
        bits = {bits[6:0], mosi2};
        nr++;
      end
      prev = sclk2;
      t2 = (nb == inj_cycle);
      if (nb == inj_cycle) d2 = inj_data;
      tick;
      guard++;
    end
    t2 = 1'b0;
    check({tag, "_timeout"}, 32'(guard >= 200), 32'd0);
    check({tag, "_busy"},    32'(nb), 32'd34);
    check({tag, "_cslow"},   32'(ncs), 32'd32);
    check({tag, "_rises"},   32'(nr), 32'd8);
    check({tag, "_bits"},    32'(bits), 32'(data));
    check({tag, "_dc"},      32'(ndc_bad), 32'd0);
  endtask

  initial begin
    int nr, g, nbytes, brun, idle, rises;
    logic prev, prevb;
    logic [7:0] bits;

    rst = 1'b1; t2 = 1'b0; dc2 = 1'b0; d2 = 8'h00; t1 = 1'b0; dc1 = 1'b0; d1 = 8'h00;
    tick;
    tick;
    rst = 1'b0;
    check("rst_busy", 32'(busy2), 32'd0);
    check("rst_cs",   32'(cs2),   32'd1);
    check("rst_sclk", 32'(sclk2), 32'd0);
    check("rst_mosi", 32'(mosi2), 32'd0);
    check("rst_dc",   32'(spidc2), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_cs1",   32'(cs1),   32'd1);
    tick;
    check("idle_busy", 32'(busy2), 32'd0);

    // Basic byte
    send_byte("a5", 1'b0, 8'hA5, -1, 8'h00);
    check("a5_dc_idle", 32'(spidc2), 32'd0);

    // Back-to-back command then data
    send_byte("b2a", 1'b0, 8'h2A, -1, 8'h00);
    check("b2a_dc_hold", 32'(spidc2), 32'd0);
    send_byte("b01", 1'b1, 8'h01, -1, 8'h00);
    check("cs_gap", 32'(gap_last), 32'd3);
    tick;
    check("b01_dc_idle", 32'(spidc2), 32'd1);

    // Stray pulse during a byte is dropped
    send_byte("ign", 1'b0, 8'h00, 10, 8'hFF);
    tick;
    check("ign_noqueue", 32'(busy2), 32'd0);

    // Reset in the fifth SCLK high phase, with transmit also high on that edge
    t2 = 1'b1; dc2 = 1'b1; d2 = 8'hC3;
    tick;
    t2 = 1'b0;
    nr = 0; g = 0;
    do begin
      prev = sclk2;
      tick;
      g++;
      if (sclk2 === 1'b1 && prev === 1'b0) nr++;
    end while (nr < 5 && g < 200);
    check("mid_reach", 32'(nr), 32'd5);
    check("mid_busy", 32'(busy2), 32'd1);
    rst = 1'b1; t2 = 1'b1;
    tick;
    rst = 1'b0; t2 = 1'b0;
    check("mid_rst_cs",   32'(cs2),    32'd1);
    check("mid_rst_sclk", 32'(sclk2),  32'd0);
    check("mid_rst_busy", 32'(busy2),  32'd0);
    check("mid_rst_mosi", 32'(mosi2),  32'd0);
    check("mid_rst_dc",   32'(spidc2), 32'd0);
    tick;
    check("rst_prio", 32'(busy2), 32'd0);
    send_byte("r3c", 1'b0, 8'h3C, -1, 8'h00);

    // CLK_DIV=1 with transmit held high
    t1 = 1'b1; dc1 = 1'b1; d1 = 8'h80;
    nbytes = 0; brun = 0; idle = 0; rises = 0; bits = 8'h00; prev = 1'b0; prevb = 1'b0; g = 0;
    tick;
    while (nbytes < 3 && g < 200) begin
      if (busy1 === 1'b1) begin
        if (prevb === 1'b0 && nbytes > 0) check("d1_reaccept", 32'(idle), 32'd1);
        brun++;
        if (sclk1 === 1'b1 && prev === 1'b0) begin
          bits = {bits[6:0], mosi1};
          rises++;
        end
      end else begin
        if (prevb === 1'b1) begin
          check("d1_busy",  32'(brun),  32'd17);
          check("d1_rises", 32'(rises), 32'd8);
          check("d1_bits",  32'(bits),  32'h80);
          nbytes++;
          brun = 0; rises = 0; bits = 8'h00; idle = 0;
        end
        idle++;
      end
      prev = sclk1;
      prevb = busy1;
      tick;
      g++;
    end
    t1 = 1'b0;
    check("d1_timeout", 32'(g >= 200), 32'd0);
    check("d1_dc", 32'(spidc1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tft_spi.md
TFT_SPI -- requirements
Module: tft_spi

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 2, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all logic is clocked on the rising edge.
REQ-003 The block SHALL have port rst  input  1  reset; it is synchronous and active-high.
REQ-004 The block SHALL have port tft_transmit  input  1  byte request strobe, sampled on the clk rising edge.
REQ-005 The block SHALL have port tft_dc  input  1  data/command flag for the requested byte (0 = command, 1 = data).
REQ-006 The block SHALL have port tft_data  input  8  byte to send.
REQ-007 The block SHALL have port tft_busy  output  1  high while a byte is in flight.
REQ-008 The block SHALL have port spi_sclk  output  1  SPI clock (mode 0, idle low).
REQ-009 The block SHALL have port spi_mosi  output  1  serial data, MSB first.
REQ-010 The block SHALL have port spi_cs  output  1  chip select, active low.
REQ-011 The block SHALL have port spi_dc  output  1  panel D/C line.

Function
REQ-012 The block SHALL implement the FSM states IDLE, LOW, HIGH and DONE; the block SHALL leave IDLE only on a rising edge where tft_transmit=1 (accept).
REQ-013 At accept the block SHALL latch tft_data into an 8-bit shift register and tft_dc into spi_dc, and from the next cycle SHALL drive tft_busy=1, spi_cs=0, spi_mosi=tft_data[7] and spi_sclk=0; the block SHALL then enter LOW.
REQ-014 In LOW the block SHALL hold spi_sclk=0 for CLK_DIV cycles, then go to HIGH.
REQ-015 In HIGH the block SHALL hold spi_sclk=1 for CLK_DIV cycles and keep spi_mosi stable across the rising SCLK edge.
REQ-016 On HIGH exit with bits remaining, the block SHALL shift the register left, drive the next bit on spi_mosi with spi_sclk=0, and return to LOW.
REQ-017 On HIGH exit after bit 0, the block SHALL set spi_sclk=0 and spi_cs=1 and enter DONE for CLK_DIV cycles with tft_busy still 1.
REQ-018 On DONE exit, the block SHALL set tft_busy=0 and return to IDLE.
REQ-019 The total tft_busy high time SHALL be exactly 17*CLK_DIV cycles per byte (34 at default).
REQ-020 A tft_transmit pulse that is not sampled in IDLE SHALL be ignored without being queued.
REQ-021 If tft_transmit is held high continuously, the block SHALL accept a new byte on the first edge in IDLE, so spi_cs stays high for at least CLK_DIV + 1 cycles between bytes.
REQ-022 spi_dc SHALL change only at accept and SHALL hold its value while idle.
REQ-023 The half-period counter SHALL be 8 bits and the bit counter 3 bits, with no wrap other than the defined terminal counts.
REQ-024 The block SHALL place no constraint on tft_data or tft_dc outside the accept edge.

Reset
REQ-025 When rst=1 on a clock edge, the block SHALL return to IDLE from any state, including mid-byte.
REQ-026 When rst=1 on a clock edge, the block SHALL drive tft_busy=0, spi_cs=1, spi_sclk=0, spi_mosi=0 and spi_dc=0 from the next cycle.
REQ-027 When rst=1 on a clock edge, the block SHALL clear both counters and the shift register.
REQ-028 rst SHALL take priority over tft_transmit on the same edge.

Structure
REQ-029 The FSM state encoding and the default CLK_DIV value SHALL reside in a shared package used by the TFT blocks.
REQ-030 The block SHALL be a single module with no sub-module, since the divider, shifter and FSM are too tightly coupled to split.

Verification
REQ-031 CLK_DIV=2, transmit with dc=0 and data=0xA5 -> tft_busy high for 34 cycles, spi_cs low for 32 cycles, mosi at the 8 SCLK rises = 1,0,1,0,0,1,0,1, spi_dc=0.
REQ-032 Send 0x2A with dc=0; after tft_busy falls send 0x01 with dc=1 -> spi_dc changes 0->1 only at the second accept, and spi_cs is high for at least 3 cycles between the bytes.
REQ-033 Pulse tft_transmit with 0xFF at cycle 10 of an in-flight 0x00 byte -> the pulse is ignored, all 8 mosi samples = 0, and tft_busy lasts 34 cycles.
REQ-034 Assert rst during the 5th SCLK high phase -> next cycle spi_cs=1, spi_sclk=0, tft_busy=0; a following transmit of 0x3C serialises correctly.
REQ-035 CLK_DIV=1 with tft_transmit held high and data=0x80 -> each byte lasts 17 busy cycles, there are 8 SCLK rises per byte, and re-accept occurs one cycle after tft_busy falls.
